// File: rtl/servo_pkg.sv
// Shared constants and helpers for the multi-channel servo PWM generator.
// Defaults describe a 20 ms period at 50 MHz with a 0.7..2.2 ms pulse range.
package servo_pkg;

  localparam int N_CANAIS_DEF  = 2;
  localparam int BITS_POS_DEF  = 3;
  localparam int PERIODO_DEF   = 1_000_000;
  localparam int LARG_MIN_DEF  = 35_000;
  localparam int LARG_MAX_DEF  = 110_000;
  localparam int PASSO_MAX_DEF = 2_500;

  // Direction of the slew step taken at a period boundary
  typedef enum logic [1:0] {
    PARADO   = 2'd0,
    SUBINDO  = 2'd1,
    DESCENDO = 2'd2
  } dir_t;

  // Linear code-to-width map; the product is formed in 64 bits so wide ranges cannot overflow
  function automatic int unsigned largura_alvo(
    input int unsigned pos,
    input int unsigned bits_pos = BITS_POS_DEF,
    input int unsigned larg_min = LARG_MIN_DEF,
    input int unsigned larg_max = LARG_MAX_DEF
  );
    longint unsigned prod;
    longint unsigned den;
    prod = longint'(pos) * longint'(larg_max - larg_min);
    den  = (longint'(1) << bits_pos) - longint'(1);
    return larg_min + int'(prod / den);
  endfunction

endpackage

// File: rtl/canal_servo_rampa.sv
// One servo channel: latches target/enable at the period boundary, slews the width, compares.
// Output is registered one cycle after contador; no backpressure, inputs sampled only at the boundary.
module canal_servo_rampa
  import servo_pkg::*;
#(
  parameter int BITS_POS  = BITS_POS_DEF,
  parameter int PERIODO   = PERIODO_DEF,
  parameter int LARG_MIN  = LARG_MIN_DEF,
  parameter int LARG_MAX  = LARG_MAX_DEF,
  parameter int PASSO_MAX = PASSO_MAX_DEF,
  parameter int CW        = $clog2(PERIODO)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [CW-1:0]       contador,
  input  logic                fim_periodo,
  input  logic [BITS_POS-1:0] posicao,
  input  logic                habilita,
  output logic                controle,
  output logic                em_movimento
);

  // A step at least as large as the period can never be exceeded, so clamp it to fit CW bits
  localparam int PASSO_SAT = (PASSO_MAX >= PERIODO) ? PERIODO - 1 : PASSO_MAX;
  localparam logic [CW-1:0] LMIN  = CW'(LARG_MIN);
  localparam logic [CW-1:0] PASSO = CW'(PASSO_SAT);

  logic [CW-1:0] largura;
  logic [CW-1:0] alvo_reg;
  logic [CW-1:0] alvo;
  logic [CW-1:0] largura_prox;
  logic          hab_reg;
  logic          inicializado;
  dir_t          dir;

  always_comb begin
    alvo         = CW'(largura_alvo(int'(posicao), BITS_POS, LARG_MIN, LARG_MAX));
    dir          = PARADO;
    largura_prox = largura;
    if (alvo > largura) begin
      dir = SUBINDO;
    end else if (alvo < largura) begin
      dir = DESCENDO;
    end
    // The first boundary after reset jumps straight to the target: there is no previous pulse to ramp from
    if (!inicializado) begin
      largura_prox = alvo;
    end else begin
      case (dir)
        SUBINDO:  largura_prox = ((alvo - largura) <= PASSO) ? alvo : largura + PASSO;
        DESCENDO: largura_prox = ((largura - alvo) <= PASSO) ? alvo : largura - PASSO;
        default:  largura_prox = largura;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      largura      <= LMIN;
      alvo_reg     <= LMIN;
      hab_reg      <= 1'b0;
      inicializado <= 1'b0;
      controle     <= 1'b0;
    end else begin
      if (fim_periodo) begin
        alvo_reg     <= alvo;
        hab_reg      <= habilita;
        largura      <= largura_prox;
        inicializado <= 1'b1;
      end
      // On the boundary cycle contador is PERIODO-1 > largura, so old and new width agree here
      controle <= hab_reg && (contador < largura);
    end
  end

  assign em_movimento = (largura != alvo_reg);

endmodule

// File: rtl/controle_servo_multi.sv
// Multi-channel servo PWM: one shared period counter feeding N_CANAIS slew-limited channels.
// controle lags contador by one cycle; no backpressure, commands are sampled once per period.
module controle_servo_multi
  import servo_pkg::*;
#(
  parameter int N_CANAIS  = N_CANAIS_DEF,
  parameter int BITS_POS  = BITS_POS_DEF,
  parameter int PERIODO   = PERIODO_DEF,
  parameter int LARG_MIN  = LARG_MIN_DEF,
  parameter int LARG_MAX  = LARG_MAX_DEF,
  parameter int PASSO_MAX = PASSO_MAX_DEF
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [N_CANAIS*BITS_POS-1:0] posicao,
  input  logic [N_CANAIS-1:0]          habilita,
  output logic [N_CANAIS-1:0]          controle,
  output logic [N_CANAIS-1:0]          db_controle,
  output logic [N_CANAIS-1:0]          em_movimento,
  output logic                         fim_periodo
);

  localparam int CW = $clog2(PERIODO);
  localparam logic [CW-1:0] ULTIMO = CW'(PERIODO - 1);

  logic [CW-1:0] contador;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      contador <= '0;
    end else if (contador == ULTIMO) begin
      contador <= '0;
    end else begin
      contador <= contador + CW'(1);
    end
  end

  assign fim_periodo = (contador == ULTIMO);

  for (genvar i = 0; i < N_CANAIS; i++) begin : g_canal
    canal_servo_rampa #(
      .BITS_POS  (BITS_POS),
      .PERIODO   (PERIODO),
      .LARG_MIN  (LARG_MIN),
      .LARG_MAX  (LARG_MAX),
      .PASSO_MAX (PASSO_MAX),
      .CW        (CW)
    ) u_canal (
      .clock        (clock),
      .reset        (reset),
      .contador     (contador),
      .fim_periodo  (fim_periodo),
      .posicao      (posicao[i*BITS_POS +: BITS_POS]),
      .habilita     (habilita[i]),
      .controle     (controle[i]),
      .em_movimento (em_movimento[i])
    );
  end

  assign db_controle = controle;

endmodule

// File: tb/tb_controle_servo_multi.sv
// Bench for controle_servo_multi with a shortened period; pulse widths are measured per period
// and compared against a per-channel width/target model updated at every boundary.
module tb_controle_servo_multi;

  localparam int N     = 2;
  localparam int B     = 3;
  localparam int P     = 300;
  localparam int LMIN  = 70;
  localparam int LMAX  = 220;
  localparam int PASSO = 5;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [N*B-1:0]   posicao = '0;
  logic [N-1:0]     habilita = '0;
  logic [N-1:0]     controle;
  logic [N-1:0]     db_controle;
  logic [N-1:0]     em_movimento;
  logic             fim_periodo;

  always #5 clock = ~clock;

  controle_servo_multi #(
    .N_CANAIS  (N),
    .BITS_POS  (B),
    .PERIODO   (P),
    .LARG_MIN  (LMIN),
    .LARG_MAX  (LMAX),
    .PASSO_MAX (PASSO)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .posicao      (posicao),
    .habilita     (habilita),
    .controle     (controle),
    .db_controle  (db_controle),
    .em_movimento (em_movimento),
    .fim_periodo  (fim_periodo)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: current width, latched target and enable per channel
  int m_larg[N];
  int m_alvo[N];
  bit m_hab[N];
  bit m_init;

  // Measurements of the last period and the model's prediction for it
  int           meas_w[N];
  int           meas_st[N];
  int           meas_fim_cnt;
  int           meas_fim_pos;
  int           meas_db_bad;
  logic [N-1:0] meas_em;
  int           pre_w[N];
  logic [N-1:0] pre_em;

  function automatic int alvo_de(int p);
    return LMIN + (p * (LMAX - LMIN)) / ((1 << B) - 1);
  endfunction

  function void model_reset();
    for (int c = 0; c < N; c++) begin
      m_larg[c] = LMIN;
      m_alvo[c] = LMIN;
      m_hab[c]  = 1'b0;
    end
    m_init = 1'b0;
  endfunction

  function void model_boundary(logic [N*B-1:0] pos, logic [N-1:0] hb);
    int t;
    for (int c = 0; c < N; c++) begin
      t = alvo_de(int'(pos[c*B +: B]));
      m_alvo[c] = t;
      m_hab[c]  = hb[c];
      if (!m_init || (t - m_larg[c] <= PASSO && m_larg[c] - t <= PASSO)) m_larg[c] = t;
      else if (t > m_larg[c]) m_larg[c] = m_larg[c] + PASSO;
      else m_larg[c] = m_larg[c] - PASSO;
    end
    m_init = 1'b1;
  endfunction

  // Runs one full period starting at a negedge where contador is 0; optional input change at sample chg_at
  task automatic run_period(input int chg_at, input logic [N*B-1:0] chg_pos, input logic [N-1:0] chg_hab);
    for (int c = 0; c < N; c++) begin
      pre_w[c]   = m_hab[c] ? m_larg[c] : 0;
      pre_em[c]  = (m_larg[c] != m_alvo[c]);
      meas_w[c]  = 0;
      meas_st[c] = -1;
    end
    meas_fim_cnt = 0;
    meas_fim_pos = -1;
    meas_db_bad  = 0;
    for (int k = 0; k < P; k++) begin
      for (int c = 0; c < N; c++) begin
        if (controle[c] === 1'b1) begin
          if (meas_w[c] == 0) meas_st[c] = k;
          meas_w[c]++;
        end
      end
      if (db_controle !== controle) meas_db_bad++;
      if (fim_periodo === 1'b1) begin
        meas_fim_cnt++;
        meas_fim_pos = k;
      end
      if (k == 0) meas_em = em_movimento;
      if (k == chg_at) begin
        posicao  = chg_pos;
        habilita = chg_hab;
      end
      @(negedge clock);
    end
    model_boundary(posicao, habilita);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    n_chk++; if (controle !== 2'b00) $display("FAIL reset_controle: got %b expected 00", controle); else n_pass++;
    n_chk++; if (db_controle !== 2'b00) $display("FAIL reset_db: got %b expected 00", db_controle); else n_pass++;
    n_chk++; if (em_movimento !== 2'b00) $display("FAIL reset_em: got %b expected 00", em_movimento); else n_pass++;
    n_chk++; if (fim_periodo !== 1'b0) $display("FAIL reset_fim: got %b expected 0", fim_periodo); else n_pass++;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_first_periods();
    posicao  = '0;
    habilita = 2'b11;
    for (int n = 0; n < 3; n++) begin
      run_period(-1, posicao, habilita);
      for (int c = 0; c < N; c++) begin
        n_chk++;
        if (meas_w[c] !== pre_w[c])
          $display("FAIL first_w%0d p%0d: got %0d expected %0d", c, n, meas_w[c], pre_w[c]);
        else n_pass++;
        if (pre_w[c] > 0) begin
          n_chk++;
          if (meas_st[c] !== 1) $display("FAIL first_start%0d: got %0d expected 1", c, meas_st[c]); else n_pass++;
        end
      end
      n_chk++;
      if (meas_fim_cnt !== 1 || meas_fim_pos !== P - 1)
        $display("FAIL fim_periodo: got count %0d at %0d expected 1 at %0d", meas_fim_cnt, meas_fim_pos, P - 1);
      else n_pass++;
      n_chk++; if (meas_db_bad !== 0) $display("FAIL db_copy: got %0d differing cycles expected 0", meas_db_bad); else n_pass++;
    end
    n_chk++; if (meas_w[0] !== LMIN) $display("FAIL first_direct: got %0d expected %0d", meas_w[0], LMIN); else n_pass++;
  endtask

  task automatic test_ramp_up();
    int reach;
    int e;
    reach = -1;
    posicao = {3'd0, 3'd7};
    for (int n = 0; n < 32; n++) begin
      run_period(-1, posicao, habilita);
      e = (LMIN + PASSO * n > LMAX) ? LMAX : LMIN + PASSO * n;
      n_chk++; if (meas_w[0] !== e) $display("FAIL ramp_w0 p%0d: got %0d expected %0d", n, meas_w[0], e); else n_pass++;
      n_chk++; if (meas_w[1] !== LMIN) $display("FAIL ramp_w1 p%0d: got %0d expected %0d", n, meas_w[1], LMIN); else n_pass++;
      n_chk++; if (meas_em !== pre_em) $display("FAIL ramp_em p%0d: got %b expected %b", n, meas_em, pre_em); else n_pass++;
      if (reach < 0 && meas_w[0] == LMAX) reach = n;
    end
    n_chk++; if (reach !== 30) $display("FAIL ramp_periods: got %0d expected 30", reach); else n_pass++;
  endtask

  task automatic test_small_step();
    int tab[7] = '{70, 75, 80, 85, 90, 91, 91};
    posicao = {3'd1, 3'd7};
    for (int n = 0; n < 7; n++) begin
      run_period(-1, posicao, habilita);
      n_chk++; if (meas_w[1] !== tab[n]) $display("FAIL step_w1 p%0d: got %0d expected %0d", n, meas_w[1], tab[n]); else n_pass++;
      n_chk++; if (meas_w[0] !== LMAX) $display("FAIL step_w0 p%0d: got %0d expected %0d", n, meas_w[0], LMAX); else n_pass++;
      n_chk++; if (meas_em !== pre_em) $display("FAIL step_em p%0d: got %b expected %b", n, meas_em, pre_em); else n_pass++;
    end
  endtask

  task automatic test_mid_change();
    run_period(P / 2, {3'd1, 3'd0}, habilita);
    n_chk++; if (meas_w[0] !== LMAX) $display("FAIL mid_current: got %0d expected %0d", meas_w[0], LMAX); else n_pass++;
    run_period(-1, posicao, habilita);
    n_chk++; if (meas_w[0] !== LMAX - PASSO) $display("FAIL mid_latched: got %0d expected %0d", meas_w[0], LMAX - PASSO); else n_pass++;
    n_chk++; if (meas_em !== pre_em) $display("FAIL mid_em: got %b expected %b", meas_em, pre_em); else n_pass++;
  endtask

  task automatic test_disable();
    run_period(30, {3'd7, 3'd0}, 2'b01);
    n_chk++; if (meas_w[1] !== 91) $display("FAIL dis_complete: got %0d expected 91", meas_w[1]); else n_pass++;
    for (int n = 0; n < 4; n++) begin
      run_period((n == 3) ? 10 : -1, posicao, (n == 3) ? 2'b11 : 2'b01);
      n_chk++; if (meas_w[1] !== 0) $display("FAIL dis_low p%0d: got %0d expected 0", n, meas_w[1]); else n_pass++;
      n_chk++; if (meas_w[0] !== pre_w[0]) $display("FAIL dis_w0 p%0d: got %0d expected %0d", n, meas_w[0], pre_w[0]); else n_pass++;
      n_chk++; if (meas_em !== pre_em) $display("FAIL dis_em p%0d: got %b expected %b", n, meas_em, pre_em); else n_pass++;
    end
    run_period(-1, posicao, habilita);
    n_chk++; if (meas_w[1] !== 91 + 5 * PASSO) $display("FAIL dis_resume: got %0d expected %0d", meas_w[1], 91 + 5 * PASSO); else n_pass++;
    n_chk++; if (meas_w[1] !== pre_w[1]) $display("FAIL dis_resume_model: got %0d expected %0d", meas_w[1], pre_w[1]); else n_pass++;
  endtask

  task automatic test_reset_mid_pulse();
    logic [N-1:0] exp_ctl;
    logic [N-1:0] exp_em;
    run_period(0, {3'd0, 3'd0}, 2'b11);
    repeat (20) @(negedge clock);
    for (int c = 0; c < N; c++) begin
      exp_ctl[c] = m_hab[c] && (m_larg[c] > 19);
      exp_em[c]  = (m_larg[c] != m_alvo[c]);
    end
    n_chk++; if (controle !== exp_ctl) $display("FAIL rst_pre_ctl: got %b expected %b", controle, exp_ctl); else n_pass++;
    n_chk++; if (em_movimento !== exp_em) $display("FAIL rst_pre_em: got %b expected %b", em_movimento, exp_em); else n_pass++;
    #2 reset = 1'b1;
    #1;
    n_chk++; if (controle !== 2'b00) $display("FAIL rst_async_ctl: got %b expected 00", controle); else n_pass++;
    n_chk++; if (em_movimento !== 2'b00) $display("FAIL rst_async_em: got %b expected 00", em_movimento); else n_pass++;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    model_reset();
    posicao  = {3'd1, 3'd7};
    habilita = 2'b11;
    run_period(-1, posicao, habilita);
    n_chk++; if (meas_w[0] !== 0 || meas_w[1] !== 0) $display("FAIL rst_silent: got %0d/%0d expected 0/0", meas_w[0], meas_w[1]); else n_pass++;
    run_period(-1, posicao, habilita);
    n_chk++; if (meas_w[0] !== LMAX) $display("FAIL rst_direct0: got %0d expected %0d", meas_w[0], LMAX); else n_pass++;
    n_chk++; if (meas_w[1] !== alvo_de(1)) $display("FAIL rst_direct1: got %0d expected %0d", meas_w[1], alvo_de(1)); else n_pass++;
    n_chk++; if (meas_em !== 2'b00) $display("FAIL rst_em_after: got %b expected 00", meas_em); else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] r;
    logic [N*B-1:0] rp;
    logic [N-1:0] rh;
    int at;
    for (int n = 0; n < 20; n++) begin
      r  = $urandom;
      rp = r[N*B-1:0];
      rh = r[N*B +: N];
      at = $urandom_range(0, P - 1);
      run_period(at, rp, rh);
      for (int c = 0; c < N; c++) begin
        n_chk++;
        if (meas_w[c] !== pre_w[c])
          $display("FAIL rand_w%0d p%0d: got %0d expected %0d", c, n, meas_w[c], pre_w[c]);
        else n_pass++;
        if (pre_w[c] > 0) begin
          n_chk++;
          if (meas_st[c] !== 1) $display("FAIL rand_start%0d p%0d: got %0d expected 1", c, n, meas_st[c]); else n_pass++;
        end
        n_chk++;
        if (m_larg[c] < LMIN || m_larg[c] > LMAX)
          $display("FAIL rand_range%0d: got %0d expected within %0d..%0d", c, m_larg[c], LMIN, LMAX);
        else n_pass++;
      end
      n_chk++; if (meas_em !== pre_em) $display("FAIL rand_em p%0d: got %b expected %b", n, meas_em, pre_em); else n_pass++;
      n_chk++; if (meas_fim_pos !== P - 1) $display("FAIL rand_fim p%0d: got %0d expected %0d", n, meas_fim_pos, P - 1); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_first_periods();
    test_ramp_up();
    test_small_step();
    test_mid_change();
    test_disable();
    test_reset_mid_pulse();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/controle_servo_multi.md
# controle_servo_multi

Parametrised multi-channel servo PWM generator, the next generation of the 3-bit single-channel `controle_servo_3`. It drives `N_CANAIS` hobby-servo lines from one shared period counter. Each channel maps a `BITS_POS`-bit position code to a pulse width and applies a per-period slew limit, so commanded jumps become ramps. It also offers per-channel enables and motion status, and sits between the position-command logic and the servo output pins.

## Interface
- `N_CANAIS`, 2: number of servo channels.
- `BITS_POS`, 3: position code width per channel.
- `PERIODO`, 1_000_000: PWM period in clock cycles (20 ms at 50 MHz).
- `LARG_MIN`, 35_000: pulse width for code 0, in cycles (0.7 ms).
- `LARG_MAX`, 110_000: pulse width for the all-ones code, in cycles (2.2 ms).
- `PASSO_MAX`, 2_500: maximum width change per period, in cycles; must be ≥1.
- Constraints: `LARG_MIN ≤ LARG_MAX < PERIODO`.
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `posicao`  in  `N_CANAIS*BITS_POS`  position codes; channel i uses `[i*BITS_POS +: BITS_POS]`.
- `habilita`  in  `N_CANAIS`  per-channel pulse enable.
- `controle`  out  `N_CANAIS`  servo PWM outputs, registered.
- `db_controle`  out  `N_CANAIS`  debug copy of `controle`.
- `em_movimento`  out  `N_CANAIS`  1 while the channel's current width differs from its latched target.
- `fim_periodo`  out  1  one-cycle strobe on the last cycle of each period.

## Operation
- `contador` counts 0..PERIODO-1 and wraps to 0. Its width is `$clog2(PERIODO)`.
- `fim_periodo` = (`contador` == PERIODO-1).
- Target width per channel: `alvo = LARG_MIN + (pos*(LARG_MAX-LARG_MIN)) / (2^BITS_POS-1)`.
  - Integer floor division.
  - Intermediate width is sufficient for `pos*(LARG_MAX-LARG_MIN)` without overflow.
- Period boundary is the cycle in which `fim_periodo`=1. At that edge, per channel:
  - `alvo_reg` ← `alvo(posicao)`.
  - `hab_reg` ← `habilita`.
  - `largura` updates:
    - If the `inicializado` flag is 0, `largura` ← `alvo` directly; this also sets `inicializado` to 1.
    - Else if |alvo−largura| ≤ PASSO_MAX, `largura` ← `alvo`.
    - Else `largura` moves PASSO_MAX toward `alvo`.
- Outside the boundary, `posicao` and `habilita` are ignored. A mid-period change never alters the pulse in progress.
- `controle[i]` next = `hab_reg[i] && (contador < largura[i])`. The pulse is exactly `largura` cycles long and starts one cycle after `contador`=0.
- A disabled channel outputs 0 but keeps ramping `largura` and updating `em_movimento`.
- `em_movimento[i]` = (`largura[i]` != `alvo_reg[i]`), driven from registers.

## Timing
- Reset values:
  - `contador`=0.
  - `largura`=LARG_MIN and `alvo_reg`=LARG_MIN.
  - `hab_reg`=0, `inicializado`=0.
  - `controle`, `db_controle`, `em_movimento` = 0.
  - `fim_periodo`=0, because the counter is 0.
- Reset asserted mid-pulse forces `controle` low asynchronously, with no wait for period end.
- The first period after reset has no pulses on any channel, because `hab_reg`=0. Pulses start from the second period at the exact target width, with no ramp.
- Latency is one cycle from `contador` to `controle`. A `posicao` change takes effect at the latest 1 period + 1 cycle later.
- A full-scale ramp at defaults takes ceil(75_000/2_500) = 30 periods (600 ms).
- `largura` never leaves [LARG_MIN, LARG_MAX].

## Structure
- Package `servo_pkg`:
  - Default timing constants (PERIODO, LARG_MIN, LARG_MAX, PASSO_MAX).
  - Function `largura_alvo(pos)`.
- The top level contains the shared period counter and `fim_periodo`.
- Sub-module `canal_servo_rampa` is instantiated `N_CANAIS` times via generate. It owns `alvo_reg`, `largura`, `hab_reg`, the slew logic, the compare and `em_movimento`.

## Test plan
1. Reset, then `habilita`=11 and codes 000/000.
   - Period 1: both outputs low.
   - From period 2: both high for exactly 35_000 of every 1_000_000 cycles.
   - `fim_periodo` pulses every 1_000_000 cycles.
2. Settled at code 000, ch0 set to 111.
   - Ch0 widths 37_500, 40_000, … reach 110_000 in the 30th period.
   - `em_movimento[0]`=1 until that boundary, then 0.
   - Ch1 is unaffected.
3. Settled at code 000, ch1 set to 001.
   - Widths 37_500, 40_000, 42_500, 45_000, then 45_714 (0.914 ms) and hold.
4. Ch0 code changed at cycle 500_000 of a period.
   - The current pulse is unchanged.
   - The new target is latched at that period's boundary.
5. `habilita[1]`→0 during a ch1 pulse.
   - The pulse completes at full width.
   - The next period is low.
   - Re-enabling resumes at the already-ramped width.
6. Reset asserted at cycle 20_000 of a pulse.
   - `controle`=00 immediately.
   - `em_movimento`=00.
   - After release, behaviour matches scenario 1: a silent first period, then the direct target width.
